// File: rtl/pc_next_unit_if.sv
// Instruction-fetch handshake between the PC unit (master) and instruction memory (slave).
interface pc_next_unit_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            imem_ready;

    modport master (output pc, output pc_valid, input imem_ready);
    modport slave  (input pc, input pc_valid, output imem_ready);
endinterface

// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection for the single-cycle core, with misaligned-target trap.
// Optional branch performance counters are enabled by defining PC_PERF_CNT_EN.
module pc_next_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch,
    input  logic                jump,
    input  logic                un_cond_branch,
    input  logic [2:0]          func3,
    input  logic                alu_zero,
    input  logic                alu_lt,
    input  logic                alu_ltu,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     rs1,
    pc_next_unit_if.master      fetch,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                taken,
    output logic                trap,
    output logic [XLEN-1:0]     epc
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]         br_cnt,
    output logic [31:0]         br_taken_cnt
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            cond, run, adv, redirect, misalign;
    logic [XLEN-1:0] target;

    always_comb begin
        cond = 1'b0;
        case (func3)
            3'b000:  cond = alu_zero;
            3'b001:  cond = ~alu_zero;
            3'b100:  cond = alu_lt;
            3'b101:  cond = ~alu_lt;
            3'b110:  cond = alu_ltu;
            3'b111:  cond = ~alu_ltu;
            default: cond = 1'b0;
        endcase
    end

    assign run      = (state_q == RUN);
    assign pc_plus4 = pc_q + XLEN'(4);
    assign redirect = un_cond_branch | jump | (branch & cond);
    assign taken    = run & redirect;

    always_comb begin
        target = pc_plus4;
        if (un_cond_branch)            target = (rs1 + imm) & ~XLEN'(1);
        else if (jump | (branch & cond)) target = pc_q + imm;
    end

    // JALR masking already clears bit 0, so only bit 1 can make a target misaligned.
    assign misalign = taken & target[1];
    assign adv      = run & fetch.pc_valid & fetch.imem_ready & ~stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        case (state_q)
            BOOT: state_d = RUN;
            TRAP: state_d = RUN;
            RUN: begin
                if (adv) begin
                    if (misalign) begin
                        epc_d   = pc_q;
                        pc_d    = TRAP_VEC;
                        state_d = TRAP;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    assign fetch.pc       = pc_q;
    assign fetch.pc_valid = run;
    assign trap           = (state_q == TRAP);
    assign epc            = epc_q;

`ifdef PC_PERF_CNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] br_taken_cnt_q, br_taken_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        br_cnt_d       = br_cnt_q;
        br_taken_cnt_d = br_taken_cnt_q;
        if (adv && branch && (br_cnt_q != 32'hFFFF_FFFF))
            br_cnt_d = br_cnt_q + 32'd1;
        if (adv && branch && cond && (br_taken_cnt_q != 32'hFFFF_FFFF))
            br_taken_cnt_d = br_taken_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q       <= '0;
            br_taken_cnt_q <= '0;
        end else begin
            br_cnt_q       <= br_cnt_d;
            br_taken_cnt_q <= br_taken_cnt_d;
        end
    end

    assign br_cnt       = br_cnt_q;
    assign br_taken_cnt = br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios then randomized cycles against a reference model.
module tb_pc_next_unit;
    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] TV   = 32'h0000_0100;
    localparam int M_BOOT = 0, M_RUN = 1, M_TRAP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, branch = 1'b0, jump = 1'b0, ucb = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
    logic [31:0] imm = '0, rs1 = '0;
    logic [31:0] pc_plus4, epc;
    logic        taken, trap;
`ifdef PC_PERF_CNT_EN
    logic [31:0] br_cnt, br_taken_cnt;
`endif

    pc_next_unit_if #(.XLEN(XLEN)) fif ();

    pc_next_unit #(.XLEN(XLEN), .RESET_VEC(RV), .TRAP_VEC(TV)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .jump(jump),
        .un_cond_branch(ucb), .func3(func3), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .alu_ltu(alu_ltu), .imm(imm), .rs1(rs1), .fetch(fif),
        .pc_plus4(pc_plus4), .taken(taken), .trap(trap), .epc(epc)
`ifdef PC_PERF_CNT_EN
        , .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural PC, mode, saved epc, counters; operands kept as values.
    logic [31:0] m_pc, m_epc, m_bc, m_btc;
    int          m_mode;
    logic [31:0] op_a, op_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RV; m_epc = '0; m_mode = M_BOOT; m_bc = '0; m_btc = '0;
    endtask

    task automatic drive(input logic u, input logic j, input logic br, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] r1, input logic st, input logic rdy);
        ucb = u; jump = j; branch = br; func3 = f3; imm = im; rs1 = r1; stall = st;
        fif.imem_ready = rdy;
        op_a = a; op_b = b;
        alu_zero = (a == b);
        alu_lt   = ($signed(a) < $signed(b));
        alu_ltu  = (a < b);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b1);
    endtask

    // Compare every output with the model, then clock once and advance the model.
    task automatic step();
        logic        c, rd, tk, ad;
        logic [31:0] tgt;
        #2;
        c   = cond_of(func3, op_a, op_b);
        rd  = ucb || jump || (branch && c);
        tk  = (m_mode == M_RUN) && rd;
        tgt = ucb ? ((rs1 + imm) & 32'hFFFF_FFFE) : (rd ? m_pc + imm : m_pc + 32'd4);
        chk("pc",       fif.pc,       m_pc);
        chk("pc_valid", fif.pc_valid, m_mode == M_RUN);
        chk("pc_plus4", pc_plus4,     m_pc + 32'd4);
        chk("taken",    taken,        tk);
        chk("trap",     trap,         m_mode == M_TRAP);
        chk("epc",      epc,          m_epc);
`ifdef PC_PERF_CNT_EN
        chk("br_cnt",       br_cnt,       m_bc);
        chk("br_taken_cnt", br_taken_cnt, m_btc);
`endif
        ad = (m_mode == M_RUN) && fif.imem_ready && !stall;
        @(posedge clk);
        if (m_mode != M_RUN) m_mode = M_RUN;
        else if (ad) begin
            if (branch && m_bc != 32'hFFFF_FFFF) m_bc++;
            if (branch && c && m_btc != 32'hFFFF_FFFF) m_btc++;
            if (tk && (tgt % 4 != 0)) begin
                m_epc = m_pc; m_pc = TV; m_mode = M_TRAP;
            end else m_pc = tgt;
        end
        #1;
    endtask

    task automatic goto(input logic [31:0] addr);
        while (m_mode != M_RUN) begin idle(); step(); end
        drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, addr - m_pc, 32'd0, 1'b0, 1'b1);
        step();
    endtask

    initial begin
        fif.imem_ready = 1'b1;
        op_a = '0; op_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", fif.pc, RV);
        chk("rst_valid", fif.pc_valid, 1'b0);
        chk("rst_trap", trap, 1'b0);
        chk("rst_epc", epc, 32'd0);
        rst_n = 1'b1;

        // Boot cycle, then sequential fetch.
        idle(); step();
        chk("boot_exit_pc", fif.pc, 32'h0);
        idle(); step();
        chk("seq_pc4", fif.pc, 32'h4);
        idle(); step();
        chk("seq_pc8", fif.pc, 32'h8);

        // beq taken / not taken from 0x10.
        goto(32'h10);
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'd5, 32'd5, -32'sd8, 32'd0, 1'b0, 1'b1);
        #1 chk("beq_taken", taken, 1'b1);
        step();
        chk("beq_pc", fif.pc, 32'h08);
        goto(32'h10);
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'd5, 32'd6, -32'sd8, 32'd0, 1'b0, 1'b1);
        step();
        chk("beq_nt_pc", fif.pc, 32'h14);

        // JALR outranks JAL; misaligned target traps.
        goto(32'h20);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'h103, 1'b0, 1'b1);
        step();
        chk("trap_pulse", trap, 1'b1);
        chk("trap_epc", epc, 32'h20);
        chk("trap_pc", fif.pc, 32'h100);
        idle(); step();
        chk("trap_over", trap, 1'b0);

        // Stall then imem not ready hold a pending jump.
        goto(32'h40);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h20, 32'd0, 1'b1, 1'b1);
            step();
        end
        chk("stall_hold", fif.pc, 32'h40);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h20, 32'd0, 1'b0, 1'b0);
            step();
        end
        chk("rdy_hold", fif.pc, 32'h40);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h20, 32'd0, 1'b0, 1'b1);
        step();
        chk("release_pc", fif.pc, 32'h60);

        // pc_plus4 wrap at the top of the address space.
        goto(32'hFFFF_FFFC);
        idle(); #1 chk("plus4_wrap", pc_plus4, 32'h0);
        step();
        chk("seq_wrap", fif.pc, 32'h0);

        // Stall wins over a pending misaligned trap.
        drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd2, 32'd0, 1'b1, 1'b1);
        step();
        chk("stall_no_trap", trap, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd2, 32'd0, 1'b0, 1'b1);
        step();
        chk("trap_after_stall", trap, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b, im;
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
            im = 32'($urandom_range(0, 255) * 2) - 32'd256;
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                  3'($urandom), a, b, im, $urandom, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) != 0);
            step();
        end

        // Counter scenario: 5 branches, 2 taken.
        goto(32'h200);
`ifdef PC_PERF_CNT_EN
        rst_n = 1'b0; #1; model_reset(); rst_n = 1'b1;
        idle(); step();
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'd7, 32'd7, 32'd8, 32'd0, 1'b0, 1'b1); step();
        drive(1'b0, 1'b0, 1'b1, 3'b001, 32'd7, 32'd7, 32'd8, 32'd0, 1'b0, 1'b1); step();
        drive(1'b0, 1'b0, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'd4, 32'd0, 1'b0, 1'b1); step();
        drive(1'b0, 1'b0, 1'b1, 3'b111, 32'd1, 32'd9, 32'd8, 32'd0, 1'b0, 1'b1); step();
        drive(1'b0, 1'b0, 1'b1, 3'b010, 32'd1, 32'd9, 32'd8, 32'd0, 1'b0, 1'b1); step();
        chk("br_cnt_5", br_cnt, 32'd5);
        chk("br_taken_cnt_2", br_taken_cnt, 32'd2);
`endif

        // Asynchronous reset mid-run takes effect without a clock edge.
        idle();
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", fif.pc, RV);
        chk("async_rst_valid", fif.pc_valid, 1'b0);
`ifdef PC_PERF_CNT_EN
        chk("async_rst_br_cnt", br_cnt, 32'd0);
        chk("async_rst_br_taken", br_taken_cnt, 32'd0);
`endif
        model_reset();
        rst_n = 1'b1;
        idle(); step();
        idle(); step();
        chk("post_rst_pc", fif.pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
